// File: rtl/risc_defs.sv
// Shared opcode and phase encodings for the 8-bit RISC core.
// Used by both the ALU and the instruction sequencer.
package risc_defs;

  localparam int OPCODE_W = 3;
  localparam int PHASE_W  = 3;

  localparam logic [OPCODE_W-1:0] HLT = 3'b000;
  localparam logic [OPCODE_W-1:0] SKZ = 3'b001;
  localparam logic [OPCODE_W-1:0] ADD = 3'b010;
  localparam logic [OPCODE_W-1:0] AND = 3'b011;
  localparam logic [OPCODE_W-1:0] XOR = 3'b100;
  localparam logic [OPCODE_W-1:0] LDA = 3'b101;
  localparam logic [OPCODE_W-1:0] STO = 3'b110;
  localparam logic [OPCODE_W-1:0] JMP = 3'b111;

  localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] STORE      = 3'd7;

  function automatic logic is_alu_op(
    input logic [OPCODE_W-1:0] op
  );
    return (op == ADD) || (op == AND) ||
           (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer: phase counter plus
// combinational control-strobe decode of phase/opcode/a_is_zero.
module risc_controller
  import risc_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                a_is_zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                halt,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr,
  output logic [PHASE_W-1:0]  phase
);

  logic frozen;
  logic alu_op;

  assign frozen = (phase == OP_ADDR) && (opcode == HLT);
  assign alu_op = is_alu_op(opcode);

  always_ff @(posedge clk) begin
    if (rst)
      phase <= INST_ADDR;
    else if (!frozen)
      phase <= phase + 3'd1;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    unique case (phase)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = (opcode == HLT);
        inc_pc = (opcode != HLT);
      end
      OP_FETCH: begin
        rd = alu_op;
      end
      ALU_OP: begin
        rd     = alu_op;
        inc_pc = (opcode == SKZ) && a_is_zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      STORE: begin
        rd     = alu_op;
        inc_pc = (opcode == JMP);
        ld_pc  = (opcode == JMP);
        ld_ac  = alu_op;
        data_e = (opcode == STO);
        wr     = (opcode == STO);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/risc_controller.md
# risc_controller

- Instruction sequencer for the 8-bit RISC core.
- Sits directly upstream of the ALU and drives the memory, IR, PC and accumulator control strobes from the current opcode.
- Steps through a fixed 8-phase cycle per instruction, decoding the 3-bit opcode and the ALU's `a_is_zero` flag into one-hot-free control lines.
- HLT freezes the core until reset.

## Interface
- Parameters: none. Opcode width is fixed at 3; phase width is fixed at 3.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 3: instruction opcode from the instruction register; same encoding the ALU consumes.
- `a_is_zero` in 1: accumulator-zero flag from the ALU.
- `sel` out 1: address mux select; 1 = PC, 0 = IR operand field.
- `rd` out 1: memory read enable.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: PC increment.
- `ld_pc` out 1: PC parallel load (jump).
- `halt` out 1: core halted.
- `data_e` out 1: accumulator drives data bus.
- `ld_ac` out 1: accumulator load from ALU output.
- `wr` out 1: memory write strobe.
- `phase` out 3: current phase, for debug and bench.

## Operation
- Opcodes:
  - HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
  - ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Phases, advancing by +1 each cycle and wrapping 7→0:
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
- Output decode per phase (unlisted outputs = 0):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD, IDLE: sel, rd, ld_ir.
  - OP_ADDR: halt = (opcode==HLT); inc_pc = (opcode!=HLT).
  - OP_FETCH: rd = ALUOP.
  - ALU_OP: rd = ALUOP; inc_pc = (opcode==SKZ && a_is_zero); ld_pc = JMP; data_e = STO.
  - STORE: rd = ALUOP; inc_pc = JMP; ld_pc = JMP; ld_ac = ALUOP; data_e = STO; wr = STO.
- Halt: in OP_ADDR with opcode==HLT, phase holds at 4 and halt stays 1 every cycle. inc_pc stays 0. Only `rst` exits.
- SKZ with a_is_zero=0: no extra PC increment. SKZ with a_is_zero=1: one extra increment in ALU_OP, skipping the next instruction.
- Unknown or X opcode is not possible with 3 bits. All 8 codes are decoded exactly as above.

## Timing
- Reset:
  - `rst` sampled high → phase=0 next cycle.
  - In INST_ADDR with any opcode, outputs are sel=1 and everything else 0.
  - Reset mid-instruction aborts the instruction immediately, with no completion of STORE. Reset overrides the halt freeze.
- Phase is the only state register. Outputs are combinational from `phase`, `opcode` and `a_is_zero`, with no added latency.
- `opcode` is sampled combinationally during phases 4–7 and must be stable from IR load (end of phase 3) onward.
- `a_is_zero` matters only in phase 6.
- One instruction = 8 cycles. The first fetch after reset deasserts: phase 0 in the first cycle.
- wr and ld_ac are asserted only in phase 7, for exactly one cycle.
- ld_pc is asserted in phases 6 and 7 for JMP (2 cycles). The PC register gives ld_pc priority over inc_pc.

## Structure
- Shared header/package `risc_defs`:
  - Opcode localparams (HLT…JMP).
  - Phase localparams (INST_ADDR…STORE).
  - `OPCODE_W=3`, `PHASE_W=3`.
- The ALU and this block both include it.
- Single module, no sub-module. An optional `risc_phase_counter` (3-bit wrap counter with synchronous clear and hold) is the only natural split; inline is preferred.

## Test plan
- Reset then free-run with opcode=ADD → phase sequence 0,1,…,7,0. In phase 7: ld_ac=1, rd=1, wr=0.
- opcode=STO → phase 6: data_e=1, wr=0. Phase 7: data_e=1, wr=1. rd=0 and ld_ac=0 throughout phases 5–7.
- opcode=SKZ, a_is_zero=1 → inc_pc=1 in phases 4 and 6. With a_is_zero=0 → inc_pc=1 in phase 4 only.
- opcode=JMP → ld_pc=1 and inc_pc=1 in phase 7, ld_pc=1 in phase 6. rd=0 in phases 5–7.
- opcode=HLT → phase reaches 4 and holds for 20 cycles with halt=1, inc_pc=0. Then `rst` pulsed → phase=0, halt=0.
- `rst` asserted in phase 6 with opcode=LDA → next cycle phase=0, ld_ac never pulses.
- Sweep all 8 opcodes × a_is_zero ∈ {0,1} against the decode list, checking every output in every phase.
